// File: rtl/vdp_cram_mixer.sv
// vdp_cram_mixer
// Final pixel stage of the VDP: merges background and sprite pixels, applies
// backdrop, left-column mask and the Game Gear window, then looks the chosen
// entry up in the 32 x 12-bit colour RAM. Two pipeline stages separate the
// incoming pixel from the RGB/de outputs. Also owns the CPU CRAM write port,
// including the two-byte write latch used by Game Gear colour writes.

module vdp_cram_mixer #(
    parameter logic [9:0] WIN_X0 = 10'd48,
    parameter logic [9:0] WIN_Y0 = 10'd24,
    parameter logic [9:0] WIN_W  = 10'd160,
    parameter logic [9:0] WIN_H  = 10'd144
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [5:0] bg_color,
    input  logic       bg_priority,
    input  logic [3:0] spr_color,
    input  logic [3:0] backdrop_idx,
    input  logic       mask_col0,
    input  logic       display_en,
    input  logic       cram_we,
    input  logic [5:0] cram_a,
    input  logic [7:0] cram_d,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       de
);

    // Exclusive window end points; all bounds stay within 10 bits, so no wrap.
    localparam logic [9:0] WIN_X1 = WIN_X0 + WIN_W;
    localparam logic [9:0] WIN_Y1 = WIN_Y0 + WIN_H;

    // Colour RAM, entry format {B, G, R}
    logic [11:0] cram [32];
    logic [7:0]  wr_latch;

    // Stage-1 combinational results
    logic       win;
    logic [3:0] bg_idx;
    logic       bg_pal;
    logic       col0;
    logic       bg_opaque;
    logic [4:0] sel_d;
    logic       black_d;

    // Stage-1 registers
    logic [4:0] sel_q;
    logic       black_q;
    logic       win_q;

    // Stage-2 read data
    logic [11:0] rd_entry;

    // The background address LSB selects the byte within an entry and has no
    // meaning for pixel colour selection.
    logic unused_bg_lsb;
    assign unused_bg_lsb = bg_color[0];

    // Window test, then priority selection of the CRAM entry for this pixel
    always_comb begin
        win       = (pixel_x >= WIN_X0) && (pixel_x < WIN_X1) &&
                    (pixel_y >= WIN_Y0) && (pixel_y < WIN_Y1);
        bg_idx    = bg_color[4:1];
        bg_pal    = bg_color[5];
        col0      = mask_col0 && (pixel_x[9:3] == 7'd0);
        bg_opaque = bg_priority && (bg_idx != 4'd0);
        sel_d     = 5'd0;
        black_d   = 1'b0;
        if (!win) begin
            sel_d   = 5'd0;
            black_d = 1'b1;
        end else if (!display_en || col0) begin
            sel_d = {1'b1, backdrop_idx};
        end else if ((spr_color != 4'd0) && !bg_opaque) begin
            sel_d = {1'b1, spr_color};
        end else begin
            sel_d = {bg_pal, bg_idx};
        end
    end

    // Stage 1: register the selected entry, the black flag and the window bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= 5'd0;
            black_q <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            black_q <= black_d;
            win_q   <= win;
        end
    end

    // CPU writes: even byte parks {G,R} in the latch, odd byte commits B plus latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_latch <= 8'd0;
            for (int i = 0; i < 32; i++) begin
                cram[i] <= 12'd0;
            end
        end else if (cram_we) begin
            if (!cram_a[0]) begin
                wr_latch <= cram_d;
            end else begin
                cram[cram_a[5:1]] <= {cram_d[3:0], wr_latch};
            end
        end
    end

    // A write landing in the same clock as this read is seen one clock later
    assign rd_entry = cram[sel_q];

    // Stage 2: register the looked-up colour, forced black outside the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r  <= 4'd0;
            g  <= 4'd0;
            b  <= 4'd0;
            de <= 1'b0;
        end else begin
            if (black_q) begin
                r <= 4'd0;
                g <= 4'd0;
                b <= 4'd0;
            end else begin
                r <= rd_entry[3:0];
                g <= rd_entry[7:4];
                b <= rd_entry[11:8];
            end
            de <= win_q;
        end
    end

endmodule

// File: tb/tb_vdp_cram_mixer.sv
// Testbench for vdp_cram_mixer
// Drives one pixel (and optional CRAM write) per clock, predicts each pixel's
// colour from a behavioural palette model and queues it; a monitor pops and
// compares two clocks later. A second instance with the window moved near the
// origin makes the left-column mask reachable.

module tb_vdp_cram_mixer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [5:0] bg_color;
    logic       bg_priority;
    logic [3:0] spr_color;
    logic [3:0] backdrop_idx;
    logic       mask_col0;
    logic       display_en;
    logic       cram_we;
    logic [5:0] cram_a;
    logic [7:0] cram_d;

    logic [3:0] r_a, g_a, b_a;
    logic       de_a;
    logic [3:0] r_b, g_b, b_b;
    logic       de_b;

    // Bench-side configuration copied onto the DUT ports with each pixel
    int bd_cfg   = 0;
    int mask_cfg = 0;
    int den_cfg  = 1;

    // Behavioural palette model
    logic [11:0] cram_m [32];
    logic [7:0]  latch_m;

    typedef struct {
        int          issue;
        int          id;
        logic [12:0] exp_a;
        logic [12:0] exp_b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int px_id  = 0;

    always #5 clk = ~clk;

    // Default-window instance (GG window at 48,24)
    vdp_cram_mixer dut_a (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .bg_color(bg_color), .bg_priority(bg_priority), .spr_color(spr_color),
        .backdrop_idx(backdrop_idx), .mask_col0(mask_col0), .display_en(display_en),
        .cram_we(cram_we), .cram_a(cram_a), .cram_d(cram_d),
        .r(r_a), .g(g_a), .b(b_a), .de(de_a)
    );

    // Window moved to 2,2 so pixels in the first 8 columns are visible
    vdp_cram_mixer #(.WIN_X0(10'd2), .WIN_Y0(10'd2)) dut_b (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .bg_color(bg_color), .bg_priority(bg_priority), .spr_color(spr_color),
        .backdrop_idx(backdrop_idx), .mask_col0(mask_col0), .display_en(display_en),
        .cram_we(cram_we), .cram_a(cram_a), .cram_d(cram_d),
        .r(r_b), .g(g_b), .b(b_b), .de(de_b)
    );

    // Expected {de, B, G, R} for a pixel given a window origin
    function automatic logic [12:0] model_px(input int x0, input int y0, input int x,
                                             input int y, input int bgc, input int bgp,
                                             input int spr);
        int sel;
        if (x < x0 || x >= x0 + 160 || y < y0 || y >= y0 + 144) return 13'h0;
        if (den_cfg == 0 || (mask_cfg == 1 && x < 8)) sel = 16 + bd_cfg;
        else if (spr != 0 && !(bgp == 1 && (bgc / 2) % 16 != 0)) sel = 16 + spr;
        else sel = bgc / 2;
        return {1'b1, cram_m[sel[4:0]]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) cram_m[i] = 12'h0;
        latch_m = 8'h0;
    endtask

    task automatic checkOutput(input string name, input int id, input logic [12:0] act,
                               input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s px%0d: got {de,bgr}=%h expected %h", name, id, act, exp);
        end
    endtask

    // One clock of stimulus: pixel inputs plus an optional CPU CRAM byte write
    task automatic applyStimulus(input int x, input int y, input int bgc, input int bgp,
                                 input int spr, input int we, input int a, input int d);
        exp_t e;
        @(negedge clk);
        pixel_x      = 10'(x);
        pixel_y      = 10'(y);
        bg_color     = 6'(bgc);
        bg_priority  = 1'(bgp);
        spr_color    = 4'(spr);
        backdrop_idx = 4'(bd_cfg);
        mask_col0    = 1'(mask_cfg);
        display_en   = 1'(den_cfg);
        cram_we      = 1'(we);
        cram_a       = 6'(a);
        cram_d       = 8'(d);
        if (we != 0) begin
            if (a % 2 == 0) latch_m = 8'(d);
            else cram_m[(a / 2) % 32] = {4'(d % 16), latch_m};
        end
        e.issue = cyc;
        e.id    = px_id;
        e.exp_a = model_px(48, 24, x, y, bgc, bgp, spr);
        e.exp_b = model_px(2, 2, x, y, bgc, bgp, spr);
        sb.push_back(e);
        px_id++;
    endtask

    task automatic writeEntry(input int entry, input int gr, input int bx);
        applyStimulus(0, 0, 0, 0, 0, 1, entry * 2, gr);
        applyStimulus(0, 0, 0, 0, 0, 1, entry * 2 + 1, bx);
    endtask

    // Monitor: each pixel's result appears two rising edges after it was driven
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].issue + 2 <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.issue + 2 < cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL missed_px px%0d: issued %0d, now %0d", mon_e.id,
                             mon_e.issue, cyc);
                end else begin
                    checkOutput("gg_window", mon_e.id, {de_a, b_a, g_a, r_a}, mon_e.exp_a);
                    checkOutput("near_origin", mon_e.id, {de_b, b_b, g_b, r_b}, mon_e.exp_b);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        pixel_x = '0; pixel_y = '0; bg_color = '0; bg_priority = 1'b0;
        spr_color = '0; backdrop_idx = '0; mask_col0 = 1'b0; display_en = 1'b1;
        cram_we = 1'b0; cram_a = '0; cram_d = '0;
        model_reset();
        #1;
        checkOutput("reset_a", -1, {de_a, b_a, g_a, r_a}, 13'h0);
        checkOutput("reset_b", -1, {de_b, b_b, g_b, r_b}, 13'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Even/odd byte pair builds entry 5 = 0x35F, then show it
        writeEntry(5, 8'h5F, 8'h03);
        applyStimulus(100, 50, 8'h0A, 0, 0, 0, 0, 0);

        // Sprite palette entry 18 = 0xABC; sprite versus background priority
        writeEntry(18, 8'hBC, 8'h0A);
        applyStimulus(100, 50, 8'h0A, 0, 2, 0, 0, 0);
        applyStimulus(100, 50, 8'h0A, 1, 2, 0, 0, 0);
        applyStimulus(100, 50, 8'h00, 1, 2, 0, 0, 0);
        applyStimulus(100, 50, 8'h00, 0, 0, 0, 0, 0);

        // Backdrop entry 19 = 0x412 (odd high nibble ignored); mask and blanking
        writeEntry(19, 8'h12, 8'hF4);
        bd_cfg   = 3;
        mask_cfg = 1;
        applyStimulus(5, 10, 8'h0A, 0, 2, 0, 0, 0);
        applyStimulus(7, 10, 8'h0A, 0, 0, 0, 0, 0);
        applyStimulus(8, 10, 8'h0A, 0, 0, 0, 0, 0);
        mask_cfg = 0;
        applyStimulus(5, 10, 8'h0A, 0, 0, 0, 0, 0);
        den_cfg = 0;
        applyStimulus(100, 50, 8'h0A, 0, 2, 0, 0, 0);
        applyStimulus(5, 10, 8'h0A, 0, 0, 0, 0, 0);
        den_cfg = 1;

        // Window edges in both directions, plus the active-area border
        foreach (sb[i]) ;
        for (int yi = 0; yi < 5; yi++) begin
            int ys[5] = '{24, 23, 167, 168, 100};
            for (int xi = 0; xi < 4; xi++) begin
                int xs[4] = '{47, 48, 207, 208};
                applyStimulus(xs[xi], ys[yi], 8'h0A, 0, 0, 0, 0, 0);
            end
        end
        applyStimulus(256, 100, 8'h0A, 0, 0, 0, 0, 0);
        applyStimulus(100, 192, 8'h0A, 0, 0, 0, 0, 0);

        // Write to entry 5 in the same clock the previous pixel reads it
        applyStimulus(100, 50, 8'h0A, 0, 0, 0, 0, 0);
        applyStimulus(100, 50, 8'h0A, 0, 0, 1, 8'h0B, 8'h07);
        applyStimulus(100, 50, 8'h0A, 0, 0, 0, 0, 0);
        applyStimulus(100, 50, 8'h0A, 0, 0, 1, 8'h0B, 8'h09);
        applyStimulus(100, 50, 8'h0A, 0, 0, 0, 0, 0);

        // Latch is shared: even byte aimed at entry 3, odd byte lands on entry 2
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h06, 8'h9C);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h05, 8'h01);
        applyStimulus(100, 50, 8'h04, 0, 0, 0, 0, 0);

        // Randomized pixels, configuration and interleaved CPU writes
        for (int n = 0; n < 400; n++) begin
            int we;
            if ($urandom_range(0, 31) == 0) begin
                bd_cfg   = int'($urandom_range(0, 15));
                mask_cfg = int'($urandom_range(0, 1));
                den_cfg  = ($urandom_range(0, 7) == 0) ? 0 : 1;
            end
            we = ($urandom_range(0, 3) == 0) ? 1 : 0;
            applyStimulus(int'($urandom_range(0, 300)), int'($urandom_range(0, 220)),
                          int'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15)),
                          we, int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
        end
        bd_cfg = 0; mask_cfg = 0; den_cfg = 1;
        applyStimulus(100, 50, 8'h0A, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-frame clears outputs at once
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_a", -1, {de_a, b_a, g_a, r_a}, 13'h0);
        checkOutput("async_rst_b", -1, {de_b, b_b, g_b, r_b}, 13'h0);
        sb.delete();
        model_reset();
        cram_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // After reset: CRAM reads zero and the latch starts at zero
        applyStimulus(100, 50, 8'h0A, 0, 0, 0, 0, 0);
        applyStimulus(100, 50, 8'h24, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'h0B, 8'h0E);
        applyStimulus(100, 50, 8'h0A, 0, 0, 0, 0, 0);
        applyStimulus(100, 50, 8'h0A, 0, 0, 0, 0, 0);

        // Let the last pixels drain through the pipeline, bounded
        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d results pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
